// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_resp_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

endpackage

// File: rtl/resp_sram.sv
// Synchronous single-port word array with a registered read port; contents survive reset.
module resp_sram
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one request, waits LATENCY cycles, commits
// the access and pulses Done with registered Busy/Err and gated read data.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Busy,
  output logic              Err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $fatal(1, "mem_responder: LATENCY must be in 1..15");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rerr_q, rerr_d;
  logic                rvalid_q, rvalid_d;
  logic                commit;
  logic                sram_we;
  logic [DATA_W-1:0]   sram_rdata;
  logic                unused_addr;

  // Bits above the word index only alias; fold them away.
  assign unused_addr = ^Addr[15:ADDR_W+1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Rd | Wr) begin
          idx_d  = Addr[ADDR_W:1];
          data_d = DataIn;
          wr_d   = Wr;
          rd_d   = Rd;
          err_d  = Addr[0] | (Rd & Wr);
          cnt_d  = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    done_d   = (state_d == RESP);
    rerr_d   = (state_d == RESP) && err_d;
    rvalid_d = (state_d == RESP) && rd_d && !err_d;
  end

  // Reset on the commit edge must suppress the write.
  assign sram_we = commit && wr_d && !err_d && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rerr_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rerr_q   <= rerr_d;
      rvalid_q <= rvalid_d;
    end
  end

  resp_sram #(
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .idx   (idx_d),
    .wdata (data_d),
    .rdata (sram_rdata)
  );

  assign DataOut = rvalid_q ? sram_rdata : '0;
  assign Done    = done_q;
  assign Busy    = busy_q;
  assign Err     = rerr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table-driven requests scored through a queue, plus reset and
// single-cycle-latency sequences.
module tb_mem_responder;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = '0, DataIn = '0, DataOut;
  logic        Rd = 1'b0, Wr = 1'b0, Done, Busy, Err;
  logic [15:0] Addr1 = '0, DataIn1 = '0, DataOut1;
  logic        Rd1 = 1'b0, Wr1 = 1'b0, Done1, Busy1, Err1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    bit          toggle;
    logic        exp_err;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t        vecs[14];
  logic [16:0] sb[$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Busy(Busy), .Err(Err)
  );

  mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .Addr(Addr1), .DataIn(DataIn1), .Rd(Rd1), .Wr(Wr1),
    .DataOut(DataOut1), .Done(Done1), .Busy(Busy1), .Err(Err1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every Done pops the oldest expected {Err, DataOut}.
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got Done=1 expected no completion at %0t", $time);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("resp_err", 16'(Err), 16'(e[16]));
        chk("resp_dout", DataOut, e[15:0]);
      end
    end
  end

  task automatic do_req(input vec_t v);
    @(posedge clk); #1;
    chk("idle_busy", 16'(Busy), 16'd0);
    Rd = v.rd; Wr = v.wr; Addr = v.addr; DataIn = v.din;
    sb.push_back({v.exp_err, v.exp_dout});
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      chk("busy", 16'(Busy), 16'd1);
      chk("done", 16'(Done), 16'(c == LAT));
      if (c < LAT) chk("dout_idle", DataOut, 16'h0000);
      if (v.toggle && c < LAT) begin
        Rd = 1'($urandom_range(0, 1)); Wr = 1'($urandom_range(0, 1));
        Addr = 16'($urandom); DataIn = 16'($urandom);
      end
      if (c == LAT) begin
        Rd = 1'b0; Wr = 1'b0;
      end
    end
  endtask

  // Write 0xAAAA to 0x0030, assert rst during cycle rc, then hold rst with a read pending.
  task automatic rst_abort(input int rc);
    @(posedge clk); #1;
    Wr = 1'b1; Addr = 16'h0030; DataIn = 16'hAAAA;
    for (int c = 1; c <= rc; c++) begin
      @(posedge clk); #1;
      if (c == rc) rst = 1'b1;
    end
    @(posedge clk); #1;
    chk("rst_busy", 16'(Busy), 16'd0);
    chk("rst_done", 16'(Done), 16'd0);
    chk("rst_err", 16'(Err), 16'd0);
    chk("rst_dout", DataOut, 16'h0000);
    Wr = 1'b0; Rd = 1'b1; Addr = 16'h0010;
    @(posedge clk); #1;
    chk("rst_blocks_accept", 16'(Busy), 16'd0);
    rst = 1'b0; Rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b1, 16'h0011, 16'h1234, 1'b0, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
    vecs[4]  = '{1'b0, 1'b1, 16'h0020, 16'h7777, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 16'h0020, 16'h9999, 1'b0, 1'b1, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h7777};
    vecs[7]  = '{1'b0, 1'b1, 16'h0202, 16'h5555, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 16'h5555};
    vecs[9]  = '{1'b1, 1'b0, 16'h0203, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 16'h0030, 16'h0123, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h0123};
    vecs[12] = '{1'b0, 1'b1, 16'h01FE, 16'hCAFE, 1'b0, 1'b0, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 16'hCAFE};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 16'(Busy), 16'd0);
    chk("reset_done", 16'(Done), 16'd0);
    chk("reset_err", 16'(Err), 16'd0);
    chk("reset_dout", DataOut, 16'h0000);
    chk("reset_busy1", 16'(Busy1), 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) do_req(vecs[i]);

    rst_abort(2);
    do_req(vecs[11]);
    rst_abort(3);
    do_req(vecs[11]);
    do_req(vecs[1]);

    // Single-cycle latency: write, then hold a read and expect Done every other cycle.
    @(posedge clk); #1;
    Wr1 = 1'b1; Addr1 = 16'h0004; DataIn1 = 16'h1111;
    @(posedge clk); #1;
    chk("l1_wr_done", 16'(Done1), 16'd1);
    chk("l1_wr_err", 16'(Err1), 16'd0);
    Wr1 = 1'b0; Rd1 = 1'b1;
    @(posedge clk); #1;
    chk("l1_idle_done", 16'(Done1), 16'd0);
    chk("l1_idle_busy", 16'(Busy1), 16'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("l1_done", 16'(Done1), 16'(k % 2));
      chk("l1_busy", 16'(Busy1), 16'(k % 2));
      chk("l1_dout", DataOut1, (k % 2 == 1) ? 16'h1111 : 16'h0000);
      chk("l1_err", 16'(Err1), 16'd0);
    end
    Rd1 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle data-memory responder serving the processor's memory stage. It accepts one read or write request at a time, holds it for a fixed parameterised latency, then commits the access and pulses `Done`. It replaces the single-cycle data memory so that stall and handshake logic in the pipeline can be exercised against a realistic slow memory. Storage is word-organised and byte-addressed: 16-bit words, `Addr[0]` must be 0.

## Interface
- `ADDR_W`, default 8: word-index width; the array holds 2^ADDR_W 16-bit words.
- `LATENCY`, default 4: cycles from request cycle to `Done` cycle. Legal range is 1..15.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high (one clock, `clk`).
- `Addr`  in  16  byte address of the request.
- `DataIn`  in  16  write data.
- `Rd`  in  1  read request.
- `Wr`  in  1  write request.
- `DataOut`  out  16  read data; valid only while `Done`=1, otherwise 0.
- `Done`  out  1  one-cycle completion pulse.
- `Busy`  out  1  a request is in flight; new requests are ignored.
- `Err`  out  1  error flag, valid with `Done`: the request was unaligned or had `Rd` and `Wr` both set.

## Operation
- States:
  - IDLE: `Busy`=0.
  - WAIT: `Busy`=1, counting.
  - RESP: `Busy`=1, `Done`=1.
- Accepting a request:
  - In IDLE, `Rd|Wr`=1 at a rising edge accepts the request.
  - On accept, latch `Addr`, `DataIn`, the op and the error condition into request registers.
  - Load the counter with LATENCY-1.
  - Go to WAIT. If LATENCY=1, go directly to RESP.
- In WAIT:
  - Each edge decrements the counter.
  - At the edge where the counter is 0, perform the access and go to RESP.
- The access itself:
  - Word index is `Addr[ADDR_W:1]`. Upper address bits are ignored, so addresses alias modulo 2^(ADDR_W+1) bytes.
  - Write: `mem[idx]` <= latched data, `DataOut`=0 in RESP.
  - Read: the `DataOut` register <= `mem[idx]`.
- Error requests (latched `Addr[0]`=1, or `Rd&Wr`=1):
  - No array access; a write is not committed.
  - They still take the full LATENCY.
  - In RESP: `Done`=1, `Err`=1, `DataOut`=0.
- RESP -> IDLE on the next edge, unconditionally.
- `Rd`/`Wr` are ignored in WAIT and RESP. The initiator holds its request until it sees `Done`, then drops or changes it.
- Array contents are not cleared by `rst`. They are undefined at power-up and preserved across reset.

## Timing
- Request presented in cycle 0 (IDLE) -> `Busy`=1 in cycles 1..LATENCY -> `Done` and `Err`/`DataOut` valid in cycle LATENCY -> IDLE in cycle LATENCY+1.
- Earliest next accept: at the edge ending cycle LATENCY+1. Back-to-back throughput is one request per LATENCY+1 cycles.
- A write becomes visible to a read accepted after its `Done`.
- Reset values: state IDLE, `Busy`=0, `Done`=0, `Err`=0, `DataOut`=0, counter 0.
- Reset mid-operation: the state returns to IDLE and the in-flight write is discarded (the array is unchanged). This holds because writes commit only at the WAIT->RESP or IDLE->RESP edge.
- Reset and commit on the same edge: reset wins and there is no write.
- `Rd`/`Wr` asserted in the same cycle `rst` is high is not accepted.
- The counter width is 4 bits. There is no wrap, because LATENCY ≤ 15 is checked at elaboration and a violation is a fatal error.

## Structure
- Package `mem_resp_pkg`:
  - state enum {IDLE, WAIT, RESP}.
  - `CNT_W`=4.
  - data width constant 16.
- Sub-module `resp_sram`: synchronous single-port array (clk, we, idx, wdata, rdata). It has no reset and is instantiated once.
- The FSM, counter, request registers and error detect stay in `mem_responder`.

## Test plan
- LATENCY=4: write 0xBEEF to 0x0010, then read 0x0010 -> `Done` in cycle 4 of each, `Busy` high in cycles 1-4, read `DataOut`=0xBEEF, `Err`=0.
- Unaligned write to 0x0011 with data 0x1234 -> `Done`+`Err` in cycle 4. A following read of 0x0010 still returns the prior value.
- `Rd`=`Wr`=1 at 0x0020 -> `Err`=1, `DataOut`=0, no write. With ADDR_W=8, a write of 0x5555 to 0x0202 is then read back at 0x0002 (alias).
- Requests toggled during `Busy` (a new address each cycle) are ignored. Only the first request completes, and the next accept happens in cycle LATENCY+1.
- `rst` pulsed in cycle 2 of a write of 0xAAAA to 0x0030 -> outputs all 0 next cycle, and a later read of 0x0030 returns the pre-write value.
- LATENCY=1: read requests held continuously -> `Done` every other cycle (1, 3, 5…) with correct data.
